a2d_spi_intf: RTL

- SPI master that answers the strt_cnv/cnv_cmplt conversion handshake issued by the line-follow motion controller.
- Drives an external 8-channel, 12-bit serial A2D (ADC128S-style) for one conversion.
- Per conversion: one addressing transaction sends the channel, a second transaction reads back the 12-bit result.
- Returns the result on res with a one-cycle cnv_cmplt pulse.

---
 rtl/a2d_spi_intf.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/a2d_spi_intf.sv
// SPI master for an 8-channel 12-bit serial A2D: one addressing transaction,
// a short deselect gap, then a read-back transaction whose low 12 bits form the result.
module a2d_spi_intf #(
    parameter int SCLK_DIV = 32,
    parameter int GAP_CLKS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        strt_cnv_i,
    input  logic [2:0]  chnnl_i,
    output logic        cnv_cmplt_o,
    output logic [11:0] res_o,
    output logic        busy_o,
    output logic        SS_n_o,
    output logic        SCLK_o,
    output logic        MOSI_o,
    input  logic        MISO_i
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int CMAX = (HALF > GAP_CLKS) ? HALF : GAP_CLKS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);
    localparam logic [5:0]    LAST_HALF = 6'd33;

    typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      half_q, half_d;
    logic [15:0]     tx_q, tx_d;
    logic [11:0]     rx_q, rx_d;
    logic            ss_q, ss_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            cmplt_q, cmplt_d;
    logic            busy_q, busy_d;
    logic [11:0]     res_q, res_d;

    // A transaction is 34 half-periods: front porch, 16 low/high pairs, back porch.
    // Only the last 12 received bits are kept, so the shift register drops rx[15:12].
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cmplt_d = 1'b0;
        busy_d  = busy_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (strt_cnv_i) begin
                    state_d = XFER1;
                    tx_d    = {2'b00, chnnl_i, 11'h000};
                    busy_d  = 1'b1;
                    ss_d    = 1'b0;
                    sclk_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                    half_d  = '0;
                end
            end
            XFER1, XFER2: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (half_q == LAST_HALF) begin
                        half_d = '0;
                        ss_d   = 1'b1;
                        sclk_d = 1'b1;
                        mosi_d = 1'b0;
                        if (state_q == XFER1) begin
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                            res_d   = rx_q;
                            cmplt_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        half_d = half_q + 6'd1;
                        if (!half_q[0] && half_q < 6'd31) begin
                            sclk_d = 1'b0;
                            mosi_d = tx_q[15];
                            tx_d   = {tx_q[14:0], 1'b0};
                        end else if (half_q[0] && half_q < 6'd32) begin
                            sclk_d = 1'b1;
                            rx_d   = {rx_q[10:0], MISO_i};
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    half_d  = '0;
                    tx_d    = '0;
                    ss_d    = 1'b0;
                    state_d = XFER2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            cmplt_q <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cmplt_q <= cmplt_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
        end
    end

    assign cnv_cmplt_o = cmplt_q;
    assign res_o       = res_q;
    assign busy_o      = busy_q;
    assign SS_n_o      = ss_q;
    assign SCLK_o      = sclk_q;
    assign MOSI_o      = mosi_q;

endmodule
